// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer
//   Serial front/back end for the time-multiplexed 4x4 CNN tile. Collects 16
//   input pixels into the parallel U frame, holds it while the tile iterates
//   for ITERS+1 sweeps of 16 cycles, snapshots the tile's Y outputs and
//   streams them back out.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input pixel handshake, in_data row-major, U1 first
//   u_frame             packed U frame, element k at [k*WIDTH +: WIDTH]
//   y_frame             packed Y outputs from the tile, same packing
//   run                 high while the tile is iterating on the held frame
//   out_valid/out_ready output pixel handshake, out_data row-major, Y1 first
//   out_last            marks the 16th output pixel (Y16)
module cnn_frame_sequencer #(
  parameter int WIDTH  = 9,
  parameter int ITERS  = 8,
  parameter int ITER_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic [16*WIDTH-1:0]   u_frame,
  input  logic [16*WIDTH-1:0]   y_frame,
  output logic                  run,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        load_cnt;
  logic [3:0]        phase;
  logic [ITER_W-1:0] sweep;
  logic [3:0]        idx;
  logic [WIDTH-1:0]  snap [16];
  logic              run_done;

  // The tile's own phase is invisible, so one extra sweep is run to make sure
  // at least ITERS complete sweeps see the new frame.
  assign run_done = (phase == 4'd15) && (sweep == ITER_W'(ITERS));

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    run       = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && load_cnt == 4'd15) state_nxt = RUN;
      end
      RUN: begin
        run = 1'b1;
        if (run_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = snap[idx];
        out_last  = (idx == 4'd15);
        if (out_ready && idx == 4'd15) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt <= '0;
      phase    <= '0;
      sweep    <= '0;
      idx      <= '0;
      u_frame  <= '0;
      for (int unsigned k = 0; k < 16; k++) snap[k] <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          // load_cnt wraps back to 0 on the 16th beat
          if (in_valid) begin
            u_frame[load_cnt*WIDTH +: WIDTH] <= in_data;
            load_cnt <= load_cnt + 4'd1;
          end
        end
        RUN: begin
          phase <= phase + 4'd1;
          if (phase == 4'd15) begin
            if (run_done) begin
              sweep <= '0;
              for (int unsigned k = 0; k < 16; k++)
                snap[k] <= y_frame[k*WIDTH +: WIDTH];
            end else begin
              sweep <= sweep + ITER_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer
//   Directed bench for cnn_frame_sequencer. Two instances (ITERS=2 and
//   ITERS=0) share the input stimulus; use_i0 selects whose outputs are
//   observed. Inputs are driven and outputs sampled on the falling edge.
module tb_cnn_frame_sequencer;

  localparam int W = 9;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic [16*W-1:0] y_frame;
  logic           out_ready;
  logic           use_i0;

  logic           in_ready2, run2, out_valid2, out_last2;
  logic [W-1:0]   out_data2;
  logic [16*W-1:0] u_frame2;
  logic           in_ready0, run0, out_valid0, out_last0;
  logic [W-1:0]   out_data0;
  logic [16*W-1:0] u_frame0;

  logic           in_ready, run, out_valid, out_last;
  logic [W-1:0]   out_data;
  logic [16*W-1:0] u_frame;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] pix   [16];
  logic [W-1:0] exp_y [16];

  always #5 clk = ~clk;

  cnn_frame_sequencer #(.WIDTH(W), .ITERS(2), .ITER_W(8)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .u_frame(u_frame2), .y_frame(y_frame), .run(run2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_last(out_last2)
  );

  cnn_frame_sequencer #(.WIDTH(W), .ITERS(0), .ITER_W(8)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .u_frame(u_frame0), .y_frame(y_frame), .run(run0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_last(out_last0)
  );

  assign in_ready  = use_i0 ? in_ready0  : in_ready2;
  assign run       = use_i0 ? run0       : run2;
  assign out_valid = use_i0 ? out_valid0 : out_valid2;
  assign out_last  = use_i0 ? out_last0  : out_last2;
  assign out_data  = use_i0 ? out_data0  : out_data2;
  assign u_frame   = use_i0 ? u_frame0   : u_frame2;

  task automatic check(input string tag, input logic [16*W-1:0] got,
                       input logic [16*W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16*W-1:0] pack_pix();
    logic [16*W-1:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[k*W +: W] = pix[k];
    return v;
  endfunction

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_idle();
    check("idle_run", run, 1'b0);
    check("idle_out_valid", out_valid, 1'b0);
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_u_frame", u_frame, '0);
  endtask

  task automatic load_frame(input bit gaps, input int npix, input bit junk);
    int unsigned g;
    for (int k = 0; k < npix; k++) begin
      if (gaps) begin
        g = $urandom_range(2, 0);
        in_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
      check("in_ready_load", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = pix[k];
      @(negedge clk);
    end
    in_valid = junk;
    in_data  = junk ? 9'h055 : '0;
  endtask

  task automatic run_phase(input int exp_cycles, input logic [16*W-1:0] y_after);
    int cnt;
    cnt = 0;
    while (run === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    y_frame = y_after;
    check("run_cycles", cnt, exp_cycles);
  endtask

  task automatic drain(input int n, input bit bp);
    int beats;
    int cyc;
    bit rdy;
    beats = 0;
    cyc = 0;
    while (beats < n && cyc < 200) begin
      check("out_valid", out_valid, 1'b1);
      check("out_data", out_data, exp_y[beats]);
      check("out_last", out_last, beats == 15);
      rdy = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      out_ready = rdy;
      @(negedge clk);
      if (rdy) beats++;
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("drain_beats", beats, n);
    if (n == 16) begin
      check("post_drain_out_valid", out_valid, 1'b0);
      check("post_drain_in_ready", in_ready, 1'b1);
    end
  endtask

  task automatic frame(input bit gaps, input bit junk, input bit bp,
                       input int run_exp, input logic [16*W-1:0] y_run,
                       input logic [16*W-1:0] y_after);
    logic [16*W-1:0] u_exp;
    u_exp = pack_pix();
    y_frame = y_run;
    for (int k = 0; k < 16; k++) exp_y[k] = y_run[k*W +: W];
    load_frame(gaps, 16, junk);
    check("u_frame_loaded", u_frame, u_exp);
    check("run_rise", run, 1'b1);
    check("in_ready_run", in_ready, 1'b0);
    run_phase(run_exp, y_after);
    drain(16, bp);
    check("u_frame_held", u_frame, u_exp);
  endtask

  function automatic logic [16*W-1:0] y_neg();
    logic [16*W-1:0] v;
    for (int k = 0; k < 16; k++) v[k*W +: W] = W'(-(k + 1));
    return v;
  endfunction

  function automatic logic [16*W-1:0] y_fill(input logic [W-1:0] val);
    logic [16*W-1:0] v;
    for (int k = 0; k < 16; k++) v[k*W +: W] = val;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    use_i0 = 1'b0;
    in_data = '0;
    y_frame = '0;

    // reset then load 1..16, ITERS=2 capture of -(k+1)
    do_reset(2);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_run", run, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_u_frame", u_frame, '0);
    for (int k = 0; k < 16; k++) pix[k] = W'(k + 1);
    frame(1'b0, 1'b0, 1'b0, 48, y_neg(), y_fill(9'h0AA));

    // backpressure 1,0,0,1
    for (int k = 0; k < 16; k++) pix[k] = W'(16 - k);
    frame(1'b0, 1'b0, 1'b1, 48, y_fill(9'h0AA) ^ y_neg(), y_fill(9'h0AA));

    // input gaps, 0x055 held during RUN/DRAIN
    for (int k = 0; k < 16; k++) pix[k] = W'(k * 37 + 200);
    frame(1'b1, 1'b1, 1'b0, 48, y_neg(), y_fill(9'h0AA));

    // reset during LOAD after 7 pixels
    load_frame(1'b0, 7, 1'b0);
    do_reset(1);
    check_idle();
    for (int k = 0; k < 16; k++) pix[k] = W'(-(k * 5 + 3));
    frame(1'b0, 1'b0, 1'b0, 48, y_neg(), y_fill(9'h0AA));

    // reset in RUN cycle 20
    load_frame(1'b0, 16, 1'b0);
    repeat (19) @(negedge clk);
    check("run_cycle20", run, 1'b1);
    do_reset(1);
    check_idle();

    // reset in DRAIN at idx 5
    y_frame = y_neg();
    for (int k = 0; k < 16; k++) exp_y[k] = W'(-(k + 1));
    load_frame(1'b0, 16, 1'b0);
    run_phase(48, y_fill(9'h0AA));
    drain(5, 1'b0);
    check("drain_idx5_data", out_data, 9'h1FA);
    do_reset(1);
    check_idle();
    for (int k = 0; k < 16; k++) pix[k] = W'(k * 11);
    frame(1'b0, 1'b0, 1'b1, 48, y_neg(), y_fill(9'h0AA));

    // ITERS=0 boundary, back-to-back frames
    use_i0 = 1'b1;
    do_reset(1);
    check_idle();
    for (int k = 0; k < 16; k++) pix[k] = 9'h100;
    for (int f = 0; f < 3; f++)
      frame(1'b0, 1'b0, 1'b0, 16, y_fill(9'h0FF), y_fill(9'h0FF));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_frame_sequencer.md
Name: cnn_frame_sequencer

Overview:
- Serial front/back end for the time-multiplexed 4x4 CNN tile.
- Accepts a stream of 16 signed input pixels and assembles them into the parallel U frame that the tile reads.
- Holds that frame stable while the tile iterates for a fixed number of 16-cycle sweeps, then snapshots the tile's 16 Y state outputs.
- Streams the snapshot back out serially, so the tile can be driven from a narrow pixel bus.

Parameters:
- WIDTH, 9, signed sample width (matches the tile datapath).
- ITERS, 8, number of full tile sweeps to run per frame (0..255).
- ITER_W, 8, width of the sweep counter; must satisfy 2^ITER_W > ITERS.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  sequencer can accept an input pixel.
- in_data  in  WIDTH  signed input pixel, row-major order, U1 first.
- u_frame  out  16*WIDTH  packed U frame to the tile; element k (U(k+1)) at bits [k*WIDTH +: WIDTH].
- y_frame  in  16*WIDTH  packed Y outputs from the tile, same packing.
- run  out  1  high while the tile result is being iterated.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output pixel.
- out_data  out  WIDTH  signed result pixel, row-major order, Y1 first.
- out_last  out  1  high with the 16th output pixel (Y16).

Behaviour:
- FSM states: LOAD, RUN, DRAIN. Reset value is LOAD.
- Reset values: load_cnt=0, sweep/cycle counters=0, drain idx=0, u_frame=0, snapshot=0.
- Output reset values: in_ready=1 (the cycle after reset deasserts), run=0, out_valid=0, out_last=0, out_data=0.
- Reset is synchronous and aborts any state immediately; partially loaded frames are discarded.

LOAD:
- in_ready=1.
- An input beat is accepted on in_valid && in_ready at a clock edge.
- The accepted pixel is written to u_frame element load_cnt, then load_cnt increments.
- Accepting the beat with load_cnt=15 moves the FSM to RUN and clears load_cnt; in_ready=0 from the next cycle.
- in_valid while in_ready=0 is ignored; no data is stored.

RUN:
- run=1, in_ready=0, out_valid=0.
- u_frame is held constant; it changes only on accepted LOAD beats.
- A 4-bit phase counter and an ITER_W sweep counter run; RUN lasts exactly (ITERS+1)*16 cycles.
- The tile's internal phase is not visible, so one extra sweep is added to cover worst-case misalignment. This makes at least ITERS complete sweeps fully sourced from the new u_frame.
- On the final RUN cycle, y_frame is captured into a 16-entry snapshot register and the FSM moves to DRAIN.
- With ITERS=0, RUN lasts 16 cycles.

DRAIN:
- out_valid=1, out_data=snapshot[idx], out_last=(idx==15).
- idx advances on out_valid && out_ready.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- Accepting idx=15 moves the FSM to LOAD; out_valid=0 and in_ready=1 from the next cycle.
- Frames do not overlap: no input is accepted during RUN or DRAIN.

Latency and arithmetic:
- Latency from the 16th input acceptance to the first out_valid is (ITERS+1)*16+1 cycles.
- No arithmetic is performed: pixels are stored and forwarded bit-exact, sign preserved.
- y_frame is sampled only once per frame.

Test Plan:
1. Reset then load: assert reset 2 cycles, then stream pixels 1..16 with in_valid held high -> in_ready=1 for exactly 16 accepts. u_frame element k equals k+1 after the last accept; run rises the next cycle.
2. RUN duration and capture, ITERS=2: after load, drive y_frame with element k = -(k+1), changed to all 0x0AA on the cycle after the expected capture -> run high exactly 48 cycles. The drain emits -1..-16 (9-bit two's complement 0x1FF..0x1F0), out_last only on -16.
3. Backpressure: during DRAIN toggle out_ready 1,0,0,1 repeatedly -> out_data/out_last stable while stalled. Exactly 16 beats are transferred in order; in_ready returns one cycle after the last beat.
4. Input gaps and ignore: insert random in_valid gaps during LOAD, and hold in_valid=1 with data 0x055 throughout RUN/DRAIN -> frame matches only the 16 accepted beats. u_frame is unchanged by 0x055.
5. Reset mid-operation: apply reset after 7 loaded pixels, and separately in RUN cycle 20 and at DRAIN idx=5 -> next cycle state LOAD, u_frame=0, out_valid=0, run=0. A following full frame processes correctly.
6. ITERS=0 boundary: load 16 pixels of 0x100 (-256), y_frame constant 0x0FF -> run high 16 cycles, 16 outputs of 0x0FF, back-to-back frames work repeatedly.
